// File: rtl/traf_phase_scheduler_pkg.sv
// Shared codes for the intersection phase scheduler: phase states, lamp codes,
// approach codes and the round-robin grant helper.
package traf_phase_scheduler_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_e;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Scan last+1, +2, +3, +0; with no requester the last grant is kept.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/traf_phase_scheduler_phase_timer.sv
// Phase timer: cleared on phase entry, counts tick pulses, saturates at all-ones.
module phase_timer
    import traf_phase_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/traf_phase_scheduler.sv
// Demand-driven 4-way phase scheduler: round-robin green grants with min/max
// green, yellow and all-red clearance, and emergency preemption.
module traf_phase_scheduler
    import traf_phase_scheduler_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emerg_valid,
    input  logic [1:0] emerg_dir,
    output logic       emerg_ack,
    output logic [2:0] North_out,
    output logic [2:0] East_out,
    output logic [2:0] South_out,
    output logic [2:0] West_out,
    output logic [1:0] active_dir,
    output logic [1:0] phase
);

    // Exit fires on the tick edge where the timer already shows N-1 ticks.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

    phase_e           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] timer;
    logic             timer_clear;
    logic             others_req;
    logic             own_req;
    logic             emerg_hold;
    logic             emerg_other;
    logic [2:0]       lamp [4];

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick),
        .count (timer)
    );

    always_comb begin
        others_req  = |(req & ~(4'b0001 << dir_q));
        own_req     = req[dir_q];
        emerg_hold  = emerg_valid && (emerg_dir == dir_q);
        emerg_other = emerg_valid && (emerg_dir != dir_q);

        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            PH_ALL_RED: begin
                if (tick && (timer >= AR_LAST)) begin
                    state_d = PH_GREEN;
                    dir_d   = emerg_valid ? emerg_dir : rr_pick(dir_q, req);
                end
            end
            PH_GREEN: begin
                if (emerg_other) begin
                    state_d = PH_YELLOW;
                end else if (tick && !emerg_hold && others_req &&
                             (((timer >= GMIN_LAST) && !own_req) || (timer >= GMAX_LAST))) begin
                    state_d = PH_YELLOW;
                end
            end
            PH_YELLOW: begin
                if (tick && (timer >= YEL_LAST)) begin
                    state_d = PH_ALL_RED;
                end
            end
            default: begin
                state_d = PH_ALL_RED;
            end
        endcase

        timer_clear = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= PH_ALL_RED;
            dir_q   <= DIR_N;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            lamp[i] = LAMP_RED;
            if (dir_q == 2'(i)) begin
                if (state_q == PH_GREEN) begin
                    lamp[i] = LAMP_GREEN;
                end else if (state_q == PH_YELLOW) begin
                    lamp[i] = LAMP_YELLOW;
                end
            end
        end
    end

    assign North_out  = lamp[DIR_N];
    assign East_out   = lamp[DIR_E];
    assign South_out  = lamp[DIR_S];
    assign West_out   = lamp[DIR_W];
    assign active_dir = dir_q;
    assign phase      = state_q;
    assign emerg_ack  = (state_q == PH_GREEN) && emerg_hold;

endmodule

// File: tb/tb_traf_phase_scheduler.sv
// Scoreboard bench for traf_phase_scheduler: directed sequences then random
// stimulus, expected outputs from an elapsed-tick reference model.
module tb_traf_phase_scheduler;

    localparam int GMIN = 5;
    localparam int GMAX = 10;
    localparam int YT   = 2;
    localparam int ART  = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] req;
    logic       emerg_valid;
    logic [1:0] emerg_dir;
    logic       emerg_ack;
    logic [2:0] North_out, East_out, South_out, West_out;
    logic [1:0] active_dir;
    logic [1:0] phase;

    always #5 clk = ~clk;

    traf_phase_scheduler #(
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .YELLOW_T  (YT),
        .ALLRED_T  (ART),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .req         (req),
        .emerg_valid (emerg_valid),
        .emerg_dir   (emerg_dir),
        .emerg_ack   (emerg_ack),
        .North_out   (North_out),
        .East_out    (East_out),
        .South_out   (South_out),
        .West_out    (West_out),
        .active_dir  (active_dir),
        .phase       (phase)
    );

    typedef struct packed {
        logic [2:0] n;
        logic [2:0] e;
        logic [2:0] s;
        logic [2:0] w;
        logic [1:0] dir;
        logic [1:0] ph;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference model: phase 0=all-red 1=green 2=yellow, elapsed = ticks seen in phase.
    int m_ph  = 0;
    int m_dir = 0;
    int m_el  = 0;

    function automatic logic [2:0] m_lamp(input int i);
        if (i != m_dir || m_ph == 0) return 3'b100;
        return (m_ph == 1) ? 3'b001 : 3'b010;
    endfunction

    task automatic model_step(input logic r, input logic t, input logic [3:0] rq,
                              input logic v, input logic [1:0] d);
        int  el;
        bit  others;
        bit  found;
        int  tgt;
        if (!r) begin
            m_ph = 0; m_dir = 0; m_el = 0;
            return;
        end
        el = m_el + 1;
        case (m_ph)
            0: if (t) begin
                if (el >= ART) begin
                    if (v) tgt = int'(d);
                    else begin
                        tgt = m_dir; found = 0;
                        for (int k = 1; k <= 4; k++)
                            if (!found && rq[(m_dir + k) % 4]) begin tgt = (m_dir + k) % 4; found = 1; end
                    end
                    m_ph = 1; m_dir = tgt; m_el = 0;
                end else m_el = el;
            end
            1: begin
                others = 0;
                for (int i = 0; i < 4; i++) if (i != m_dir && rq[i]) others = 1;
                if (v && int'(d) != m_dir) begin
                    m_ph = 2; m_el = 0;
                end else if (t) begin
                    if (!(v && int'(d) == m_dir) && others &&
                        ((el >= GMIN && !rq[m_dir]) || el >= GMAX)) begin
                        m_ph = 2; m_el = 0;
                    end else m_el = el;
                end
            end
            default: if (t) begin
                if (el >= YT) begin m_ph = 0; m_el = 0; end
                else m_el = el;
            end
        endcase
    endtask

    task automatic drive(input logic r, input logic t, input logic [3:0] rq,
                         input logic v, input logic [1:0] d);
        exp_t x;
        reset = r; tick = t; req = rq; emerg_valid = v; emerg_dir = d;
        model_step(r, t, rq, v, d);
        x.n = m_lamp(0); x.e = m_lamp(1); x.s = m_lamp(2); x.w = m_lamp(3);
        x.dir = 2'(m_dir);
        x.ph  = 2'(m_ph);
        x.ack = (m_ph == 1) && v && (int'(d) == m_dir);
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Ticks on every other cycle so a tick interval spans two clocks.
    task automatic run(input int n, input logic [3:0] rq, input logic v, input logic [1:0] d);
        for (int i = 0; i < n; i++) drive(1'b1, 1'(i % 2), rq, v, d);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    initial begin : driver
        logic [3:0] rq;
        logic       v;
        logic [1:0] d;
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 4'b1111, 1'b1, 2'd3);
        run(70,  4'b0000, 1'b0, 2'd0);
        run(40,  4'b0010, 1'b0, 2'd0);
        run(60,  4'b0011, 1'b0, 2'd0);
        run(180, 4'b1111, 1'b0, 2'd0);
        run(60,  4'b1111, 1'b1, 2'd2);
        run(40,  4'b1111, 1'b0, 2'd0);
        run(20,  4'b1111, 1'b1, 2'd1);
        run(20,  4'b1111, 1'b1, 2'd3);
        run(11,  4'b1111, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 2'd0);
        rq = 4'b0000; v = 1'b0; d = 2'd0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 19) == 0) rq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) v = ~v;
            if ($urandom_range(0, 79) == 0) d = 2'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 999) != 0), 1'($urandom_range(0, 2) == 0), rq, v, d);
        end
        done = 1'b1;
    end

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("north",      int'(North_out),  int'(x.n));
                chk("east",       int'(East_out),   int'(x.e));
                chk("south",      int'(South_out),  int'(x.s));
                chk("west",       int'(West_out),   int'(x.w));
                chk("active_dir", int'(active_dir), int'(x.dir));
                chk("phase",      int'(phase),      int'(x.ph));
                chk("emerg_ack",  int'(emerg_ack),  int'(x.ack));
            end else if (done) begin
                break;
            end else begin
                chk("scoreboard_empty", 0, 1);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
